// File: rtl/sd_card_resp.sv
// ---------------------------------------------------------------------------
// sd_card_resp
//
// SPI-mode SD card responder. This is the card side of the SD initialisation
// handshake, intended as a bench model and as an FPGA loopback target.
// 48-bit host command frames are deserialised from SD_MOSI. The card tracks
// its idle/ready state and answers on SD_MISO with R1 (8-bit) or R7 (40-bit)
// responses, so a host CMD0 / CMD8 / CMD55 / ACMD41 init sequence completes.
//
// Parameters
//   NCR_CYC      cycles from the frame end-bit sample to the response MSB (1..255)
//   ACMD41_BUSY  number of ACMD41s answered busy (0x01) before ready (0x00)
//   VHS_OK       accepted CMD8 voltage-supplied field
//
// Ports
//   SD_CK      in   SPI clock; the only clock, all logic on posedge
//   rst_n      in   asynchronous active-low reset
//   SD_CSn     in   chip select, active low
//   SD_MOSI    in   host->card serial data, MSB first
//   SD_MISO    out  card->host serial data, MSB first, idles high
//   card_idle  out  card in idle state (R1 bit0)
//   cmd_valid  out  one-cycle pulse when a frame is accepted
//   cmd_idx    out  command index of the last accepted frame
//
// Build option
//   SD_RESP_CRC_EN  when defined, CMD0/CMD8 frames carry a checked CRC7.
//                   A mismatch is answered with the CRC-error R1 and changes
//                   no card state. When undefined, no CRC logic is built.
// ---------------------------------------------------------------------------

module sd_card_resp #(
  parameter int unsigned NCR_CYC     = 8,
  parameter int unsigned ACMD41_BUSY = 2,
  parameter logic [3:0]  VHS_OK      = 4'h1
) (
  input  logic       SD_CK,
  input  logic       rst_n,
  input  logic       SD_CSn,
  input  logic       SD_MOSI,
  output logic       SD_MISO,
  output logic       card_idle,
  output logic       cmd_valid,
  output logic [5:0] cmd_idx
);

  typedef enum logic [1:0] {
    StListen,
    StCmd,
    StNcr,
    StResp
  } state_e;

  localparam logic [7:0] NcrLoad  = 8'(NCR_CYC - 1);
  localparam logic [7:0] BusyLoad = 8'(ACMD41_BUSY);

  state_e      state_q;
  logic [46:0] shift_q;     // frame bits received so far, newest in bit 0
  logic [5:0]  bit_cnt_q;   // frame bit index of the most recently stored bit
  logic [7:0]  ncr_cnt_q;
  logic [39:0] resp_q;      // response, left aligned, shifted out from bit 39
  logic [5:0]  rem_q;       // response bits still to drive after the current one
  logic [7:0]  busy_cnt_q;
  logic        app_flag_q;

  // Full frame as it stands on the edge that samples the end bit.
  logic [47:0] frame;
  logic        frame_ok;

  assign frame    = {shift_q, SD_MOSI};
  assign frame_ok = frame[46] & frame[0];

  // Argument bits only partly consumed by the decoder.
  logic unused_frame_bits;
  assign unused_frame_bits = ^{frame[47], frame[39:20], frame[7:1]};

  // ---------------------------------------------------------------------------
  // CRC7 check (optional)
  // ---------------------------------------------------------------------------
  logic crc_bad;

`ifdef SD_RESP_CRC_EN
  function automatic logic [6:0] crc7(input logic [39:0] data);
    logic [6:0] crc;
    logic       fb;
    crc = '0;
    for (int i = 39; i >= 0; i--) begin
      fb  = data[i] ^ crc[6];
      crc = {crc[5:0], 1'b0};
      if (fb) begin
        crc = crc ^ 7'h09;
      end
    end
    return crc;
  endfunction

  always_comb begin
    crc_bad = 1'b0;
    if ((frame[45:40] == 6'd0) || (frame[45:40] == 6'd8)) begin
      crc_bad = (crc7(frame[47:8]) != frame[7:1]);
    end
  end
`else
  assign crc_bad = 1'b0;
`endif

  // ---------------------------------------------------------------------------
  // Command decode: response contents and next card state, evaluated on the
  // end-bit edge and only committed when the frame is accepted.
  // ---------------------------------------------------------------------------
  logic [7:0]  r1;
  logic        is_r7;
  logic        idle_d;
  logic [7:0]  busy_d;
  logic        app_d;
  logic [3:0]  vhs;
  logic [39:0] resp_d;
  logic [5:0]  rem_d;

  always_comb begin
    r1     = {5'b0, 1'b1, 1'b0, card_idle};  // illegal command
    is_r7  = 1'b0;
    idle_d = card_idle;
    busy_d = busy_cnt_q;
    app_d  = 1'b0;                           // any frame but CMD55 ends the app prefix
    vhs    = (frame[19:16] == VHS_OK) ? frame[19:16] : 4'h0;

    if (crc_bad) begin
      r1    = {4'b0, 1'b1, 2'b0, card_idle};
      app_d = app_flag_q;
    end else begin
      case (frame[45:40])
        6'd0: begin
          r1     = 8'h01;
          idle_d = 1'b1;
          busy_d = BusyLoad;
        end
        6'd8: begin
          r1    = {7'b0, card_idle};
          is_r7 = 1'b1;
        end
        6'd55: begin
          r1    = {7'b0, card_idle};
          app_d = 1'b1;
        end
        6'd41: begin
          if (app_flag_q) begin
            if (busy_cnt_q != 8'd0) begin
              busy_d = busy_cnt_q - 8'd1;
              r1     = {7'b0, card_idle};
            end else begin
              idle_d = 1'b0;
              r1     = 8'h00;
            end
          end
        end
        default: ;
      endcase
    end

    resp_d = is_r7 ? {r1, 16'h0000, 4'h0, vhs, frame[15:8]} : {r1, 32'hFFFF_FFFF};
    rem_d  = is_r7 ? 6'd39 : 6'd7;
  end

  // ---------------------------------------------------------------------------
  // Main FSM with registered outputs
  // ---------------------------------------------------------------------------
  always_ff @(posedge SD_CK or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StListen;
      shift_q    <= '0;
      bit_cnt_q  <= '0;
      ncr_cnt_q  <= '0;
      resp_q     <= '1;
      rem_q      <= '0;
      busy_cnt_q <= BusyLoad;
      app_flag_q <= 1'b0;
      SD_MISO    <= 1'b1;
      card_idle  <= 1'b1;
      cmd_valid  <= 1'b0;
      cmd_idx    <= '0;
    end else begin
      cmd_valid <= 1'b0;

      if (SD_CSn) begin
        // Deselect drops any partial frame or response; card state survives.
        state_q <= StListen;
        SD_MISO <= 1'b1;
      end else begin
        case (state_q)
          StListen: begin
            SD_MISO <= 1'b1;
            if (!SD_MOSI) begin
              shift_q   <= '0;
              bit_cnt_q <= 6'd47;
              state_q   <= StCmd;
            end
          end

          StCmd: begin
            SD_MISO   <= 1'b1;
            shift_q   <= frame[46:0];
            bit_cnt_q <= bit_cnt_q - 6'd1;
            if (bit_cnt_q == 6'd1) begin
              // This edge samples the end bit.
              if (frame_ok) begin
                cmd_valid  <= 1'b1;
                cmd_idx    <= frame[45:40];
                card_idle  <= idle_d;
                busy_cnt_q <= busy_d;
                app_flag_q <= app_d;
                resp_q     <= resp_d;
                rem_q      <= rem_d;
                ncr_cnt_q  <= NcrLoad;
                state_q    <= StNcr;
              end else begin
                state_q <= StListen;
              end
            end
          end

          StNcr: begin
            if (ncr_cnt_q == 8'd0) begin
              SD_MISO <= resp_q[39];
              resp_q  <= {resp_q[38:0], 1'b1};
              state_q <= StResp;
            end else begin
              SD_MISO   <= 1'b1;
              ncr_cnt_q <= ncr_cnt_q - 8'd1;
            end
          end

          StResp: begin
            if (rem_q != 6'd0) begin
              SD_MISO <= resp_q[39];
              resp_q  <= {resp_q[38:0], 1'b1};
              rem_q   <= rem_q - 6'd1;
            end else begin
              // LSB has been on the line for a cycle; a start bit may already
              // be arriving on this same edge.
              SD_MISO <= 1'b1;
              if (!SD_MOSI) begin
                shift_q   <= '0;
                bit_cnt_q <= 6'd47;
                state_q   <= StCmd;
              end else begin
                state_q <= StListen;
              end
            end
          end

          default: begin
            SD_MISO <= 1'b1;
            state_q <= StListen;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_sd_card_resp.sv
module tb_sd_card_resp;

  localparam int unsigned NCR  = 8;
  localparam int unsigned BUSY = 2;
  localparam int          W    = NCR + 52;

  logic       SD_CK;
  logic       rst_n;
  logic       SD_CSn;
  logic       SD_MOSI;
  logic       SD_MISO;
  logic       card_idle;
  logic       cmd_valid;
  logic [5:0] cmd_idx;

  int n_checks;
  int n_errors;

  // Reference card state
  bit         mdl_idle;
  int         mdl_busy;
  bit         mdl_app;
  logic [5:0] mdl_idx;

  sd_card_resp #(
    .NCR_CYC    (NCR),
    .ACMD41_BUSY(BUSY),
    .VHS_OK     (4'h1)
  ) dut (
    .SD_CK    (SD_CK),
    .rst_n    (rst_n),
    .SD_CSn   (SD_CSn),
    .SD_MOSI  (SD_MOSI),
    .SD_MISO  (SD_MISO),
    .card_idle(card_idle),
    .cmd_valid(cmd_valid),
    .cmd_idx  (cmd_idx)
  );

  initial SD_CK = 1'b0;
  always #5 SD_CK = ~SD_CK;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // CRC7 as polynomial long division of M(x)*x^7 by x^7+x^3+1.
  function automatic logic [6:0] crc7_div(input logic [39:0] m);
    logic [46:0] v;
    logic [46:0] g;
    v = {m, 7'b0};
    for (int i = 46; i >= 7; i--) begin
      if (v[i]) begin
        g = 47'h89 << (i - 7);
        v = v ^ g;
      end
    end
    return v[6:0];
  endfunction

  function automatic logic [47:0] mk_frame(input logic [5:0] idx, input logic [31:0] arg);
    logic [39:0] h;
    h = {2'b01, idx, arg};
    return {h, crc7_div(h), 1'b1};
  endfunction

  task automatic model_reset();
    mdl_idle = 1'b1;
    mdl_busy = BUSY;
    mdl_app  = 1'b0;
    mdl_idx  = 6'd0;
  endtask

  // Expected response (right aligned) and length for an accepted frame.
  task automatic model_cmd(input logic [47:0] f, output logic [39:0] r, output int len);
    int         idx;
    logic [31:0] arg;
    logic [7:0] r1;
    logic [3:0] v;
    bit         crc_good;
    idx      = int'(f[45:40]);
    arg      = f[39:8];
    len      = 8;
    crc_good = 1'b1;
`ifdef SD_RESP_CRC_EN
    crc_good = (crc7_div(f[47:8]) == f[7:1]);
`endif
    mdl_idx = f[45:40];
    if (!crc_good && (idx == 0 || idx == 8)) begin
      r = 40'(8'h08 + 8'(mdl_idle));
      return;
    end
    if (idx == 0) begin
      r1 = 8'h01;
      mdl_idle = 1'b1;
      mdl_busy = BUSY;
      mdl_app  = 1'b0;
    end else if (idx == 8) begin
      r1  = 8'(mdl_idle);
      v   = (arg[11:8] == 4'h1) ? arg[11:8] : 4'h0;
      len = 40;
      mdl_app = 1'b0;
      r = {r1, 8'h00, 8'h00, 4'h0, v, arg[7:0]};
      return;
    end else if (idx == 55) begin
      r1 = 8'(mdl_idle);
      mdl_app = 1'b1;
    end else if (idx == 41 && mdl_app) begin
      if (mdl_busy > 0) begin
        mdl_busy--;
        r1 = 8'(mdl_idle);
      end else begin
        mdl_idle = 1'b0;
        r1 = 8'h00;
      end
      mdl_app = 1'b0;
    end else begin
      r1 = 8'h04 + 8'(mdl_idle);
      mdl_app = 1'b0;
    end
    r = 40'(r1);
  endtask

  // Send a frame (abort_at >= 0 raises SD_CSn instead of that bit) and check
  // the host-side view of the following window.
  task automatic run_frame(input logic [47:0] f, input int abort_at, input string tag);
    logic [39:0] er;
    logic [39:0] got;
    int          elen;
    bit          expect_resp;
    logic        win [W];
    logic        got_valid;
    logic        pulse;
    logic [5:0]  got_idx;
    int          first0;
    bit          tail_ones;
    bit          any_zero;

    expect_resp = (abort_at < 0) && f[46] && f[0];
    er   = '0;
    elen = 8;
    if (expect_resp) model_cmd(f, er, elen);

    for (int i = 47; i >= 0; i--) begin
      @(negedge SD_CK);
      if (abort_at == i) begin
        SD_CSn  = 1'b1;
        SD_MOSI = 1'b1;
        break;
      end
      SD_CSn  = 1'b0;
      SD_MOSI = f[i];
    end

    @(negedge SD_CK);
    got_valid = cmd_valid;
    got_idx   = cmd_idx;
    win[0]    = SD_MISO;
    SD_CSn    = 1'b0;
    SD_MOSI   = 1'b1;
    pulse     = 1'b0;
    for (int k = 1; k < W; k++) begin
      @(negedge SD_CK);
      if (k == 1) pulse = cmd_valid;
      win[k] = SD_MISO;
    end

    if (expect_resp) begin
      check_eq({tag, "_valid"}, 64'(got_valid), 64'd1);
      check_eq({tag, "_pulse"}, 64'(pulse), 64'd0);
      check_eq({tag, "_idx"}, 64'(got_idx), 64'(f[45:40]));
      first0 = -1;
      for (int k = 0; k < W; k++) begin
        if (first0 < 0 && win[k] == 1'b0) first0 = k;
      end
      check_eq({tag, "_ncr"}, 64'(first0), 64'(NCR));
      if (first0 < 0) first0 = 0;
      got = '0;
      for (int j = 0; j < elen; j++) got = {got[38:0], win[first0 + j]};
      check_eq({tag, "_resp"}, 64'(got), 64'(er));
      tail_ones = 1'b1;
      for (int k = first0 + elen; k < W; k++) if (win[k] !== 1'b1) tail_ones = 1'b0;
      check_eq({tag, "_tail"}, 64'(tail_ones), 64'd1);
    end else begin
      check_eq({tag, "_novalid"}, 64'(got_valid | pulse), 64'd0);
      any_zero = 1'b0;
      for (int k = 0; k < W; k++) if (win[k] !== 1'b1) any_zero = 1'b1;
      check_eq({tag, "_nomiso"}, 64'(any_zero), 64'd0);
      check_eq({tag, "_keepidx"}, 64'(got_idx), 64'(mdl_idx));
    end
    check_eq({tag, "_idle"}, 64'(card_idle), 64'(mdl_idle));
  endtask

  task automatic check_reset_state(input string tag);
    check_eq({tag, "_miso"}, 64'(SD_MISO), 64'd1);
    check_eq({tag, "_idle"}, 64'(card_idle), 64'd1);
    check_eq({tag, "_valid"}, 64'(cmd_valid), 64'd0);
    check_eq({tag, "_idx"}, 64'(cmd_idx), 64'd0);
  endtask

  initial begin
    logic [47:0] f;
    logic [5:0]  idx;
    logic [31:0] arg;
    int          sel;
    int          ab;

    n_checks = 0;
    n_errors = 0;
    rst_n    = 1'b0;
    SD_CSn   = 1'b1;
    SD_MOSI  = 1'b1;
    model_reset();
    repeat (3) @(negedge SD_CK);
    check_reset_state("reset");
    rst_n = 1'b1;
    @(negedge SD_CK);

    // Init handshake
    run_frame(48'h40_0000_0000_95, -1, "cmd0");
    run_frame(48'h48_0000_01AA_87, -1, "cmd8");
    for (int i = 0; i < 3; i++) begin
      run_frame(48'h77_0000_0000_65, -1, "cmd55");
      run_frame(48'h69_4000_0000_77, -1, "acmd41");
    end
    check_eq("init_ready", 64'(card_idle), 64'd0);
    run_frame(48'h7A_0000_0000_FF, -1, "cmd58_ready");

    // Asynchronous reset in the middle of a frame
    f = 48'h48_0000_01AA_87;
    for (int i = 47; i >= 28; i--) begin
      @(negedge SD_CK);
      SD_CSn  = 1'b0;
      SD_MOSI = f[i];
    end
    @(negedge SD_CK);
    rst_n = 1'b0;
    #1;
    model_reset();
    check_reset_state("midrst");
    @(negedge SD_CK);
    SD_MOSI = 1'b1;
    rst_n   = 1'b1;
    @(negedge SD_CK);

    // Deselect during CMD8, then normal CMD0
    run_frame(48'h48_0000_01AA_87, 20, "cmd8_abort");
    run_frame(48'h40_0000_0000_95, -1, "cmd0_after_abort");
    run_frame(48'h7A_0000_0000_FF, -1, "cmd58");
    run_frame(48'h69_4000_0000_77, -1, "cmd41_noapp");
    run_frame(48'h40_0000_0000_01, -1, "cmd0_badcrc");
    run_frame(48'h48_0000_01AA_86, -1, "cmd8_badend");

    // Randomized traffic
    for (int n = 0; n < 70; n++) begin
      sel = int'($urandom_range(0, 8));
      case (sel)
        0:       idx = 6'd0;
        1, 2:    idx = 6'd8;
        3, 4:    idx = 6'd55;
        5, 6:    idx = 6'd41;
        7:       idx = 6'd58;
        default: idx = 6'($urandom_range(0, 63));
      endcase
      arg = $urandom;
      if (idx == 6'd8 && $urandom_range(0, 1) == 1) begin
        arg = {20'h0, 4'($urandom_range(0, 2)), 8'($urandom_range(0, 255))};
      end
      f  = mk_frame(idx, arg);
      ab = -1;
      if ($urandom_range(0, 9) == 0) ab = int'($urandom_range(1, 46));
      if ($urandom_range(0, 15) == 0) f[0] = 1'b0;
      run_frame(f, ab, "rnd");
      if ($urandom_range(0, 4) == 0) begin
        SD_CSn = 1'b1;
        repeat (int'($urandom_range(1, 4))) @(negedge SD_CK);
      end
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
